// File: rtl/jstk_spi_reader.sv
// Polls a two-axis SPI joystick (mode 0, five-byte frame) and turns each complete
// frame into registered axis samples plus edge-detected direction/button pulses.
module jstk_spi_reader #(
    parameter int CLK_DIV     = 50,
    parameter int SS_SETUP    = 1500,
    parameter int BYTE_GAP    = 1000,
    parameter int POLL_PERIOD = 1000000,
    parameter int LOW_TH      = 300,
    parameter int HIGH_TH     = 700
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       joystick_MISO,
    output logic       joystick_SS,
    output logic       joystick_MOSI,
    output logic       joystick_SCLK,
    output logic [9:0] x_pos,
    output logic [9:0] y_pos,
    output logic       pressed,
    output logic       up,
    output logic       down,
    output logic       left,
    output logic       right,
    output logic       frame_done
);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, GAP, DONE} state_t;

    localparam int M1      = (POLL_PERIOD > SS_SETUP) ? POLL_PERIOD : SS_SETUP;
    localparam int M2      = (BYTE_GAP > 2 * CLK_DIV) ? BYTE_GAP : 2 * CLK_DIV;
    localparam int CNT_MAX = (M1 > M2) ? M1 : M2;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] POLL_LAST   = CW'(POLL_PERIOD - 1);
    localparam logic [CW-1:0] SETUP_LAST  = CW'(SS_SETUP - 1);
    localparam logic [CW-1:0] GAP_LAST    = CW'(BYTE_GAP - 1);
    localparam logic [CW-1:0] HALF        = CW'(CLK_DIV);
    localparam logic [CW-1:0] HALF_LAST   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] PERIOD_LAST = CW'(2 * CLK_DIV - 1);
    localparam logic [9:0]    LOW_V       = 10'(LOW_TH);
    localparam logic [9:0]    HIGH_V      = 10'(HIGH_TH);

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [2:0]    bit_idx, bit_next;
    logic [2:0]    byte_idx, byte_next;
    logic [7:0]    shift_reg;
    logic [7:0]    x_lo, y_lo;
    logic [1:0]    x_hi, y_hi;
    logic [4:0]    lvl, prev_lvl, pulse;   // {pressed, up, down, left, right}

    logic       sample, byte_end, frame_end;
    logic [9:0] new_x, new_y;
    logic [4:0] new_lvl;

    always_comb begin
        state_next = state;
        cnt_next   = cnt + 1'b1;
        bit_next   = bit_idx;
        byte_next  = byte_idx;
        case (state)
            IDLE: begin
                if (cnt == POLL_LAST) begin
                    state_next = SETUP;
                    cnt_next   = '0;
                end
            end
            SETUP: begin
                if (cnt == SETUP_LAST) begin
                    state_next = SHIFT;
                    cnt_next   = '0;
                    bit_next   = '0;
                    byte_next  = '0;
                end
            end
            SHIFT: begin
                if (cnt == PERIOD_LAST) begin
                    cnt_next = '0;
                    if (bit_idx == 3'd7) begin
                        bit_next   = '0;
                        state_next = (byte_idx == 3'd4) ? DONE : GAP;
                    end else begin
                        bit_next = bit_idx + 1'b1;
                    end
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    state_next = SHIFT;
                    cnt_next   = '0;
                    byte_next  = byte_idx + 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
                cnt_next   = '0;
                byte_next  = '0;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
                bit_next   = '0;
                byte_next  = '0;
            end
        endcase
    end

    // MISO is captured on the same edge that raises SCLK.
    assign sample    = (state == SHIFT) && (cnt == HALF_LAST);
    assign byte_end  = (state == SHIFT) && (cnt == PERIOD_LAST) && (bit_idx == 3'd7);
    assign frame_end = byte_end && (byte_idx == 3'd4);

    // Byte 4 is still in the shift register when the frame closes.
    assign new_x   = {x_hi, x_lo};
    assign new_y   = {y_hi, y_lo};
    assign new_lvl = {shift_reg[0], new_y > HIGH_V, new_y < LOW_V, new_x < LOW_V, new_x > HIGH_V};

    // NOTE: every register here uses <= so all updates see the pre-edge values;
    // the SPI pins are registered from next-state values so they stay glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            bit_idx       <= '0;
            byte_idx      <= '0;
            shift_reg     <= '0;
            x_lo          <= '0;
            x_hi          <= '0;
            y_lo          <= '0;
            y_hi          <= '0;
            x_pos         <= '0;
            y_pos         <= '0;
            lvl           <= '0;
            prev_lvl      <= '0;
            pulse         <= '0;
            frame_done    <= 1'b0;
            joystick_SS   <= 1'b1;
            joystick_SCLK <= 1'b0;
            joystick_MOSI <= 1'b0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            bit_idx       <= bit_next;
            byte_idx      <= byte_next;
            joystick_SS   <= (state_next == IDLE) || (state_next == DONE);
            joystick_SCLK <= (state_next == SHIFT) && (cnt_next >= HALF);
            joystick_MOSI <= (state_next == SHIFT) && (byte_next == 3'd0) && (bit_next == 3'd0);
            frame_done    <= frame_end;

            if (sample)
                shift_reg <= {shift_reg[6:0], joystick_MISO};

            if (byte_end) begin
                case (byte_idx)
                    3'd0:    x_lo <= shift_reg;
                    3'd1:    x_hi <= shift_reg[1:0];
                    3'd2:    y_lo <= shift_reg;
                    3'd3:    y_hi <= shift_reg[1:0];
                    default: ;
                endcase
            end

            if (frame_end) begin
                x_pos    <= new_x;
                y_pos    <= new_y;
                lvl      <= new_lvl;
                prev_lvl <= lvl;
            end

            pulse <= (state == DONE) ? (lvl & ~prev_lvl) : 5'b0;
        end
    end

    assign {pressed, up, down, left, right} = pulse;

endmodule

// File: tb/tb_jstk_spi_reader.sv
// Scoreboard bench for jstk_spi_reader: an SPI slave model serves queued frames,
// a reference model predicts axes and pulses, and a monitor checks each frame.
`timescale 1ns/1ps
module tb_jstk_spi_reader;

    localparam int LOW_TH  = 300;
    localparam int HIGH_TH = 700;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       miso = 1'b0;
    logic       ss, mosi, sclk;
    logic [9:0] x_pos, y_pos;
    logic       pressed, up, down, left, right, frame_done;

    jstk_spi_reader #(
        .CLK_DIV(2), .SS_SETUP(4), .BYTE_GAP(3), .POLL_PERIOD(20),
        .LOW_TH(LOW_TH), .HIGH_TH(HIGH_TH)
    ) dut (
        .clk(clk), .rst(rst), .joystick_MISO(miso), .joystick_SS(ss),
        .joystick_MOSI(mosi), .joystick_SCLK(sclk), .x_pos(x_pos), .y_pos(y_pos),
        .pressed(pressed), .up(up), .down(down), .left(left), .right(right),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [4:0] p;   // {pressed, up, down, left, right}
    } exp_t;

    int          checks = 0;
    int          fails  = 0;
    exp_t        sb_q[$];
    logic [39:0] slave_q[$];
    logic [4:0]  model_prev = '0;
    logic        abort = 1'b0;
    int          rises = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        fails++;
        $display("FAIL %s: timed out", name);
    endtask

    // SPI slave: presents MSB of the frame at SS fall, shifts on SCLK fall, records MOSI on SCLK rise.
    logic [39:0] cur_frame = '0;
    logic [39:0] rx = '0;
    int          k = 0;
    logic        prev_ss = 1'b1, prev_sclk = 1'b0;

    always @(negedge clk) begin
        if (!ss && prev_ss) begin
            cur_frame = (slave_q.size() > 0) ? slave_q.pop_front() : 40'h0;
            k     = 0;
            rises = 0;
            rx    = '0;
            miso  = cur_frame[39];
        end else if (!ss) begin
            if (sclk && !prev_sclk) begin
                if (rises < 40) rx[39 - rises] = mosi;
                rises++;
            end
            if (!sclk && prev_sclk) begin
                k++;
                miso = (k < 40) ? cur_frame[39 - k] : 1'b0;
            end
        end
        if (ss && !prev_ss) begin
            if (abort) begin
                abort = 1'b0;
            end else begin
                check("sclk_rises", 64'(rises), 64'd40);
                check("mosi_bits", 64'(rx), 64'h80_0000_0000);
            end
            miso = 1'b0;
        end
        prev_ss   = ss;
        prev_sclk = sclk;
    end

    // Monitor: pops the scoreboard on frame_done, checks pulses the following cycle.
    logic       pend = 1'b0;
    logic [4:0] pend_val = '0;
    logic [9:0] last_x = '0, last_y = '0;

    always @(negedge clk) begin
        if (pend) begin
            check("pulses", 64'({pressed, up, down, left, right}), 64'(pend_val));
            pend = 1'b0;
        end else if ({pressed, up, down, left, right} != 5'b0) begin
            check("stray_pulse", 64'({pressed, up, down, left, right}), 64'd0);
        end
        if (frame_done) begin
            if (sb_q.size() == 0) begin
                timeout("unexpected_frame_done");
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("x_pos", 64'(x_pos), 64'(e.x));
                check("y_pos", 64'(y_pos), 64'(e.y));
                pend     = 1'b1;
                pend_val = e.p;
            end
        end else if (!rst && (x_pos != last_x || y_pos != last_y)) begin
            check("axes_stable", 64'({x_pos, y_pos}), 64'({last_x, last_y}));
        end
        last_x = x_pos;
        last_y = y_pos;
    end

    // Reference model: thresholds and edge detection straight from the frame contents.
    task automatic issue_frame(input int x, input int y, input logic [7:0] b4, input logic [5:0] jx, input logic [5:0] jy);
        logic [9:0] xv, yv;
        logic [4:0] lv;
        exp_t       e;
        xv = 10'(x);
        yv = 10'(y);
        slave_q.push_back({xv[7:0], jx, xv[9:8], yv[7:0], jy, yv[9:8], b4});
        lv[4] = b4[0];
        lv[3] = (y > HIGH_TH);
        lv[2] = (y < LOW_TH);
        lv[1] = (x < LOW_TH);
        lv[0] = (x > HIGH_TH);
        e.x = xv;
        e.y = yv;
        e.p = lv & ~model_prev;
        model_prev = lv;
        sb_q.push_back(e);
    endtask

    task automatic wait_frame(input string name);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) timeout(name);
        repeat (2) @(negedge clk);
    endtask

    task automatic run_frame(input int x, input int y, input logic [7:0] b4);
        issue_frame(x, y, b4, 6'd0, 6'd0);
        wait_frame("frame_wait");
    endtask

    task automatic release_and_time(input string name);
        int n;
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            n++;
            #1;
            if (!ss) break;
        end
        check(name, 64'(n), 64'd20);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ss", 64'(ss), 64'd1);
        check("rst_sclk", 64'(sclk), 64'd0);
        check("rst_mosi", 64'(mosi), 64'd0);
        check("rst_axes", 64'({x_pos, y_pos}), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);

        // Centred frame, then the first SS fall is timed from reset release.
        issue_frame(512, 512, 8'h00, 6'd0, 6'd0);
        release_and_time("first_ss_fall");
        wait_frame("frame_wait");

        run_frame(512, 1023, 8'h01);   // up + press
        run_frame(512, 1023, 8'h01);   // held: nothing
        run_frame(700, 512, 8'h00);    // boundary: neutral
        run_frame(701, 512, 8'h00);    // right
        run_frame(300, 512, 8'h00);    // boundary: neutral
        run_frame(299, 512, 8'h00);    // left
        run_frame(512, 512, 8'h00);
        run_frame(0, 1023, 8'h00);     // diagonal left + up
        run_frame(512, 512, 8'h00);
        run_frame(0, 1023, 8'h00);     // diagonal again
        run_frame(800, 200, 8'h00);    // right + down, leaves non-zero axes

        // Abort a frame during byte 2.
        begin
            int n;
            issue_frame(850, 100, 8'h01, 6'd0, 6'd0);
            n = 0;
            while (!(rises >= 20 && !ss) && n < 300) begin
                @(negedge clk);
                n++;
            end
            if (!(rises >= 20 && !ss)) timeout("reach_byte2");
            abort = 1'b1;
            rst   = 1'b1;
            @(posedge clk);
            #1;
            check("midrst_ss", 64'(ss), 64'd1);
            check("midrst_sclk", 64'(sclk), 64'd0);
            check("midrst_mosi", 64'(mosi), 64'd0);
            check("midrst_x_pos", 64'(x_pos), 64'd0);
            check("midrst_y_pos", 64'(y_pos), 64'd0);
            sb_q.delete();
            slave_q.delete();
            model_prev = '0;
            @(negedge clk);
            issue_frame(100, 900, 8'h01, 6'd0, 6'd0);   // left + up + press after reset
            release_and_time("ss_fall_after_midrst");
            wait_frame("frame_wait");
        end

        // Random frames, including junk in the ignored upper bits.
        for (int i = 0; i < 10; i++) begin
            int         rx_v, ry_v;
            logic [7:0] b4;
            rx_v = $urandom_range(0, 1023);
            ry_v = $urandom_range(0, 1023);
            b4   = 8'($urandom);
            issue_frame(rx_v, ry_v, b4, 6'($urandom), 6'($urandom));
            wait_frame("rand_frame_wait");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/jstk_spi_reader.md
JSTK_SPI_READER -- requirements
Module: jstk_spi_reader

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50: SCLK half-period in clk cycles, giving 1 MHz at a 100 MHz clk.
REQ-002 SHALL have parameter SS_SETUP, default 1500: cycles from SS falling to the first SCLK edge.
REQ-003 SHALL have parameter BYTE_GAP, default 1000: idle cycles between bytes, SS held low.
REQ-004 SHALL have parameter POLL_PERIOD, default 1000000: cycles from the end of one frame (or from reset release) to the next SS falling.
REQ-005 SHALL have parameters LOW_TH, default 300, and HIGH_TH, default 700: 10-bit axis thresholds.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port joystick_MISO, input, 1 bit: serial data from the joystick.
REQ-009 SHALL have port joystick_SS, output, 1 bit: chip select, active low.
REQ-010 SHALL have port joystick_MOSI, output, 1 bit: serial command to the joystick.
REQ-011 SHALL have port joystick_SCLK, output, 1 bit: SPI clock, mode 0.
REQ-012 SHALL have ports x_pos and y_pos, output, 10 bits each: last complete axis samples.
REQ-013 SHALL have ports pressed, up, down, left and right, output, 1 bit each: single-cycle event pulses.
REQ-014 SHALL have port frame_done, output, 1 bit: one-cycle pulse when a frame completes.

Function
REQ-015 SHALL implement FSM states IDLE, SETUP, SHIFT, GAP and DONE.
REQ-016 IDLE SHALL hold SS=1 and SCLK=0, count POLL_PERIOD cycles, then go to SETUP.
REQ-017 SETUP SHALL drive SS=0 and wait SS_SETUP cycles, then go to SHIFT with byte index 0.
REQ-018 SHIFT SHALL send 8 SCLK periods, each CLK_DIV cycles low then CLK_DIV cycles high, MSB first.
- MISO is sampled on the clk cycle where SCLK rises.
- MOSI changes only while SCLK is low, valid from the start of the period.
REQ-019 MOSI SHALL send 0x80 for byte 0 and 0x00 for bytes 1-4.
REQ-020 After each byte, FSM SHALL go to GAP (SS=0, SCLK=0) for BYTE_GAP cycles, then SHIFT for the next byte.
REQ-021 After byte 4, FSM SHALL go to DONE instead of GAP.
REQ-022 Received bytes SHALL be stored in order: b0 X[7:0], b1 X[9:8] in bits 1:0, b2 Y[7:0], b3 Y[9:8] in bits 1:0, b4 buttons with bit0 the stick button; other bits ignored.
REQ-023 DONE SHALL last exactly one cycle, with SS=1.
- x_pos, y_pos and direction levels update in this cycle.
- frame_done=1 in this cycle.
- Next state IDLE; poll counter restarts at 0.
REQ-024 Direction levels SHALL be unsigned strict compares:
- up = Y > HIGH_TH; down = Y < LOW_TH.
- right = X > HIGH_TH; left = X < LOW_TH.
- press = b4[0].
- A value equal to a threshold is neutral.
- Diagonals may assert two levels simultaneously.
REQ-025 Each of pressed/up/down/left/right SHALL pulse high for exactly the cycle after DONE, only when its new level is 1 and its previous-frame level was 0.
- Held directions produce no further pulses.
- Release-then-press across frames produces a new pulse.
REQ-026 Outputs SHALL be registered, with no combinational path from MISO to any output.
REQ-027 x_pos and y_pos SHALL change only in DONE and never show partial frames.

Reset
REQ-028 On rst=1 at a clk edge, the following SHALL hold on the next cycle, including mid-frame:
- FSM=IDLE, all counters=0.
- SS=1, SCLK=0, MOSI=0.
- x_pos=0, y_pos=0, previous levels=0, all pulses and frame_done=0.
- Partial frame data discarded.
REQ-029 The first SS falling after reset release SHALL occur exactly POLL_PERIOD cycles later.

Verification (CLK_DIV=2, SS_SETUP=4, BYTE_GAP=3, POLL_PERIOD=20, LOW_TH=300, HIGH_TH=700)
REQ-030 Frame shape: SPI model returns bytes 0x00,0x02,0x00,0x02,0x00 (X=Y=512) -> exactly 40 SCLK rises; MOSI bits 1000_0000 then zeros; x_pos=512, y_pos=512; frame_done once; no direction pulses.
REQ-031 Up plus press: Y=0x3FF, X=512, b4=0x01 -> up and pressed pulse one cycle together after DONE; the next identical frame gives no pulses.
REQ-032 Threshold boundary: X=700 then X=701 -> no right pulse for 700, right pulse for 701; X=300 -> no left pulse, X=299 -> left pulse.
REQ-033 Reset mid-frame: rst asserted during byte 2 SHIFT -> next cycle SS=1, SCLK=0, x_pos=0; next SS falling exactly 20 cycles after rst deasserts; following frame decodes correctly.
REQ-034 Diagonal and repeat: X=0,Y=1023 -> left and up pulse together; then neutral frame; then same diagonal -> both pulse again.
